// File: rtl/gcd_engine.sv
// Handshaked GCD engine: subtractive Euclid or binary (Stein) algorithm per transaction,
// reporting gcd(a,b) and the number of iteration cycles spent in CALC.
module gcd_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic [CNT_WIDTH-1:0]  cycles_o
);

  localparam int K_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [K_WIDTH-1:0]   K_ONE   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  mode_q;
  logic [K_WIDTH-1:0]    k_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  finished;
  logic [DATA_WIDTH-1:0] result;
  logic [CNT_WIDTH-1:0]  cnt_next;

  // Termination is judged on the registered operands before any update this cycle.
  always_comb begin
    finished = (a_q == b_q) || (a_q == '0) || (b_q == '0);
    result   = ((a_q == '0) ? b_q : a_q) << k_q;
    cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  end

  // NOTE: every register in the single state machine uses non-blocking assignment, so all
  // right-hand sides read the values from before the clock edge regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      gcd_o       <= '0;
      cycles_o    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      k_q         <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            a_q        <= operand_a_i;
            b_q        <= operand_b_i;
            mode_q     <= mode_i;
            k_q        <= '0;
            cnt_q      <= '0;
            in_ready_o <= 1'b0;
            state      <= S_CALC;
          end
        end

        S_CALC: begin
          cnt_q <= cnt_next;
          if (finished) begin
            gcd_o       <= result;
            cycles_o    <= cnt_next;
            out_valid_o <= 1'b1;
            state       <= S_DONE;
          end else if (!mode_q) begin
            if (a_q > b_q) a_q <= a_q - b_q;
            else           b_q <= b_q - a_q;
          end else begin
            // Binary rules in priority order; common factors of two are counted in k.
            if (!a_q[0] && !b_q[0]) begin
              a_q <= a_q >> 1;
              b_q <= b_q >> 1;
              k_q <= k_q + K_ONE;
            end else if (!a_q[0]) begin
              a_q <= a_q >> 1;
            end else if (!b_q[0]) begin
              b_q <= b_q >> 1;
            end else if (a_q > b_q) begin
              a_q <= a_q - b_q;
            end else begin
              b_q <= b_q - a_q;
            end
          end
        end

        S_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: begin
          state       <= S_IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: a producer pushes expected results, a monitor/consumer pops
// and compares them; a narrow-counter instance shares the inputs to cover cycles_o saturation.
`timescale 1ns/1ps
module tb_gcd_engine;

  localparam int DW = 8;

  logic          clk_i   = 1'b0;
  logic          reset_i = 1'b0;
  logic          in_valid_i;
  logic [DW-1:0] operand_a_i;
  logic [DW-1:0] operand_b_i;
  logic          mode_i;
  logic          out_ready_i = 1'b0;

  logic          in_ready_o,  in_ready_s;
  logic          out_valid_o, out_valid_s;
  logic [DW-1:0] gcd_o,       gcd_s;
  logic [15:0]   cycles_o;
  logic [3:0]    cycles_s;

  gcd_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .mode_i(mode_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .gcd_o(gcd_o), .cycles_o(cycles_o)
  );

  gcd_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_s),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .mode_i(mode_i),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready_i),
    .gcd_o(gcd_s), .cycles_o(cycles_s)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int gcd;
    int cycles;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   errors     = 0;
  bit   hold_ready = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // Reference gcd by remainder Euclid.
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive step count from Euclid quotients: a run of q subtractions per division.
  function automatic int ref_sub_cycles(input int a, input int b);
    int steps = 0;
    int t, q, r;
    while (a != 0 && b != 0 && a != b) begin
      if (a < b) begin
        t = a; a = b; b = t;
      end
      q = a / b;
      r = a % b;
      if (r == 0) begin
        steps += q - 1;
        a = b;
      end else begin
        steps += q;
        a = r;
      end
    end
    return steps + 1;
  endfunction

  function automatic int ref_bin_cycles(input int a, input int b);
    int steps = 0;
    while (!(a == b || a == 0 || b == 0)) begin
      if (a % 2 == 0 && b % 2 == 0) begin
        a = a / 2;
        b = b / 2;
      end else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0)     b = b / 2;
      else if (a > b)          a = a - b;
      else                     b = b - a;
      steps++;
    end
    return steps + 1;
  endfunction

  // Producer: offer one operand pair and wait (bounded) for it to be accepted.
  task automatic send(input int a, input int b, input bit mode, input bit push,
                      input int exp_gcd, input int exp_cycles);
    exp_t e;
    bit   taken = 1'b0;
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    operand_a_i = DW'(a);
    operand_b_i = DW'(b);
    mode_i      = mode;
    for (int n = 0; n < 4000; n++) begin
      if (in_ready_o) begin
        taken = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!taken) begin
      check("accept_timeout", 0, 1);
    end else begin
      if (push) begin
        e.gcd    = exp_gcd;
        e.cycles = exp_cycles;
        sb_q.push_back(e);
      end
      @(posedge clk_i);
      #1;
      in_valid_i  = 1'b0;
      operand_a_i = DW'($urandom);
      operand_b_i = DW'($urandom);
      mode_i      = 1'($urandom);
    end
  endtask

  task automatic send_model(input int a, input int b, input bit mode);
    send(a, b, mode, 1'b1, ref_gcd(a, b), mode ? ref_bin_cycles(a, b) : ref_sub_cycles(a, b));
  endtask

  task automatic wait_drain();
    bit drained = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk_i);
      if (sb_q.size() == 0 && !out_valid_o && in_ready_o) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) check("drain_timeout", 0, 1);
  endtask

  // Monitor and consumer: compare on the first cycle a result is presented, then re-check
  // the held result every cycle until the handshake completes.
  initial begin
    bit   seen = 1'b0;
    exp_t cur;
    cur.gcd    = 0;
    cur.cycles = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        seen = 1'b0;
      end else begin
        if (out_valid_o) begin
          if (!seen) begin
            if (sb_q.size() == 0) begin
              check("unexpected_result", 1, 0);
            end else begin
              cur = sb_q.pop_front();
              check("gcd", gcd_o, cur.gcd);
              check("cycles", cycles_o, sat(cur.cycles, 65535));
              check("sat_gcd", gcd_s, cur.gcd);
              check("sat_cycles", cycles_s, sat(cur.cycles, 15));
              check("sat_valid", out_valid_s, 1);
            end
            seen = 1'b1;
          end else begin
            check("held_gcd", gcd_o, cur.gcd);
            check("held_cycles", cycles_o, sat(cur.cycles, 65535));
            check("held_in_ready", in_ready_o, 0);
          end
        end
        out_ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (out_valid_o && out_ready_i) seen = 1'b0;
      end
    end
  end

  initial begin
    bit got;
    int a, b;
    in_valid_i  = 1'b0;
    operand_a_i = '0;
    operand_b_i = '0;
    mode_i      = 1'b0;

    #1 reset_i = 1'b1;
    #1;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_gcd", gcd_o, 0);
    check("rst_cycles", cycles_o, 0);
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;

    // Directed cases with hand-derived results.
    send(12, 18, 1'b0, 1'b1, 6, 3);
    send(12, 18, 1'b1, 1'b1, 6, 5);
    send(0, 7, 1'b0, 1'b1, 7, 1);
    send(0, 7, 1'b1, 1'b1, 7, 1);
    send(0, 0, 1'b0, 1'b1, 0, 1);
    send(0, 0, 1'b1, 1'b1, 0, 1);
    send(7, 0, 1'b1, 1'b1, 7, 1);
    send(255, 1, 1'b0, 1'b1, 1, 255);
    wait_drain();

    // Consumer stalls in DONE while the producer holds a new pair valid.
    hold_ready = 1'b1;
    send_model(20, 8, 1'b0);
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    operand_a_i = 8'd9;
    operand_b_i = 8'd6;
    mode_i      = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (out_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    check("stall_reached_done", got, 1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      check("stall_out_valid", out_valid_o, 1);
      check("stall_in_ready", in_ready_o, 0);
    end
    hold_ready = 1'b0;
    send_model(9, 6, 1'b1);
    wait_drain();

    // Asynchronous reset in the middle of a computation.
    send(200, 75, 1'b0, 1'b0, 0, 0);
    repeat (2) @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_in_ready", in_ready_o, 1);
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_gcd", gcd_o, 0);
    check("midrst_cycles", cycles_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("postrst_in_ready", in_ready_o, 1);
    send(200, 75, 1'b1, 1'b1, 25, ref_bin_cycles(200, 75));
    wait_drain();

    // Random pairs in both modes, with occasional zero operands.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 400; i++) begin
        a = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
        b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
        send_model(a, b, 1'(m));
      end
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
